conv_psum_post: RTL

- Sits directly downstream of conv_pe and consumes its o_acc/o_vld stream of per-pixel 3x3 partial sums, TOUT output channels per pixel.
- Accumulates partial sums over cfg_num_tiles input-channel tiles for one output row held in an on-chip row buffer.
- On the last tile it adds bias, round-shifts, applies optional ReLU, saturates to int8 and emits a packed TOUT-byte pixel toward the OFM buffer.

---
 rtl/conv_psum_post_if.sv | 22 ++
 rtl/conv_psum_post.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/conv_psum_post_if.sv
// Stream bundle between conv_pe, the partial-sum post-processor and the OFM writer.
interface conv_psum_post_if #(
  parameter int TOUT   = 4,
  parameter int W_PSUM = 20,
  parameter int W_SIZE = 9
);
  logic [TOUT*W_PSUM-1:0] pe_acc;
  logic                   pe_vld;
  logic [TOUT*8-1:0]      o_data;
  logic                   o_vld;
  logic [W_SIZE-1:0]      o_col;

  modport master (
    output pe_acc, pe_vld,
    input  o_data, o_vld, o_col
  );

  modport slave (
    input  pe_acc, pe_vld,
    output o_data, o_vld, o_col
  );
endinterface

// File: rtl/conv_psum_post.sv
// Accumulates conv_pe partial sums over input-channel tiles in a row buffer,
// then adds bias, round-shifts, optionally ReLUs and saturates to int8 per lane.
//
// state | meaning
// IDLE  | waiting for cfg_start; pe_vld ignored
// RUN   | accepting pe_vld beats for the current row
module conv_psum_post #(
  parameter int TOUT    = 4,
  parameter int W_PSUM  = 20,
  parameter int W_ACC   = 32,
  parameter int W_BIAS  = 16,
  parameter int MAX_W   = 256,
  parameter int W_SIZE  = 9,
  parameter int W_TILE  = 8,
  parameter int W_SHIFT = 5
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   cfg_start,
  input  logic [W_SIZE-1:0]      cfg_width,
  input  logic [W_TILE-1:0]      cfg_num_tiles,
  input  logic [W_SHIFT-1:0]     cfg_shift,
  input  logic                   cfg_relu,
  input  logic [TOUT*W_BIAS-1:0] bias_flat,
  conv_psum_post_if.slave        bus,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int AW = (MAX_W > 1) ? $clog2(MAX_W) : 1;
  localparam logic [W_SIZE:0] MAX_W_L = (W_SIZE+1)'(MAX_W);
  localparam logic signed [W_ACC:0] SAT_HI = (W_ACC+1)'(127);
  localparam logic signed [W_ACC:0] SAT_LO = -(W_ACC+1)'(128);

  typedef enum logic [0:0] {IDLE, RUN} state_t;

  state_t state, state_nx;

  logic [W_SIZE-1:0]      width_q;
  logic [W_TILE-1:0]      tiles_q;
  logic [W_SHIFT-1:0]     shift_q;
  logic                   relu_q;
  logic [TOUT*W_BIAS-1:0] bias_q;

  logic [W_SIZE-1:0]      col;
  logic [W_TILE-1:0]      tile;
  logic [AW-1:0]          col_a;

  logic cfg_ok, load, abort, err_nx, accept, last_col, last_tile;

  logic [TOUT*W_ACC-1:0]  row_buf [MAX_W];
  logic [TOUT*W_ACC-1:0]  buf_rd, wr_flat, s1_nx, s1_x;
  logic                   s1_vld, s1_last;
  logic [W_SIZE-1:0]      s1_col;

  logic [TOUT*8-1:0]      o_data_nx, o_data_q;
  logic                   o_vld_q;
  logic [W_SIZE-1:0]      o_col_q;
  logic signed [W_ACC:0]  rnd;

  assign cfg_ok    = (cfg_width != '0) && ({1'b0, cfg_width} <= MAX_W_L) && (cfg_num_tiles != '0);
  assign last_col  = (col == width_q - W_SIZE'(1));
  assign last_tile = (tile == tiles_q - W_TILE'(1));
  assign accept    = (state == RUN) && bus.pe_vld && !cfg_start;
  assign col_a     = col[AW-1:0];
  assign busy      = (state == RUN);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    abort    = 1'b0;
    err_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_start) begin
          if (cfg_ok) begin
            load     = 1'b1;
            state_nx = RUN;
          end else begin
            err_nx   = 1'b1;
          end
        end
      end
      RUN: begin
        if (cfg_start) begin
          abort = 1'b1;
          if (cfg_ok) begin
            load     = 1'b1;
          end else begin
            err_nx   = 1'b1;
            state_nx = IDLE;
          end
        end else if (bus.pe_vld && last_col && last_tile) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      width_q <= '0;
      tiles_q <= '0;
      shift_q <= '0;
      relu_q  <= 1'b0;
      bias_q  <= '0;
      col     <= '0;
      tile    <= '0;
      err     <= 1'b0;
    end else begin
      err <= err_nx;
      if (load) begin
        width_q <= cfg_width;
        tiles_q <= cfg_num_tiles;
        shift_q <= cfg_shift;
        relu_q  <= cfg_relu;
        bias_q  <= bias_flat;
        col     <= '0;
        tile    <= '0;
      end else if (accept) begin
        if (last_col) begin
          col  <= '0;
          tile <= tile + W_TILE'(1);
        end else begin
          col  <= col + W_SIZE'(1);
        end
      end
    end
  end

  // Asynchronous read sees the previous cycle's write, which covers width==1 back-to-back updates.
  assign buf_rd = row_buf[col_a];

  always_ff @(posedge clk) begin
    if (accept && !last_tile) row_buf[col_a] <= wr_flat;
  end

  always_comb begin
    rnd = '0;
    if (shift_q != '0) rnd = (W_ACC+1)'(1) <<< (shift_q - W_SHIFT'(1));
  end

  for (genvar t = 0; t < TOUT; t++) begin : g_lane
    logic signed [W_PSUM-1:0] p;
    logic signed [W_BIAS-1:0] b;
    logic signed [W_ACC-1:0]  s, acc_rd, wr, x;
    logic signed [W_ACC:0]    xe, r;
    logic signed [7:0]        q;

    assign p      = bus.pe_acc[(TOUT-t)*W_PSUM-1 -: W_PSUM];
    assign b      = bias_q[(TOUT-t)*W_BIAS-1 -: W_BIAS];
    assign s      = W_ACC'(p);
    assign acc_rd = buf_rd[(TOUT-t)*W_ACC-1 -: W_ACC];
    assign wr     = (tile == '0) ? s : acc_rd + s;

    assign wr_flat[(TOUT-t)*W_ACC-1 -: W_ACC] = wr;
    assign s1_nx[(TOUT-t)*W_ACC-1 -: W_ACC]   = wr + W_ACC'(b);

    assign x  = s1_x[(TOUT-t)*W_ACC-1 -: W_ACC];
    assign xe = (W_ACC+1)'(x);

    always_comb begin
      r = (xe + rnd) >>> shift_q;
      if (relu_q && (r < 0)) r = '0;
      if (r > SAT_HI)      q = 8'sd127;
      else if (r < SAT_LO) q = -8'sd128;
      else                 q = r[7:0];
    end

    assign o_data_nx[(TOUT-t)*8-1 -: 8] = q;
  end

  // Abort kills stage 1 via accept=0 and blocks stage 2 from committing what stage 1 holds.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_vld   <= 1'b0;
      s1_last  <= 1'b0;
      s1_col   <= '0;
      s1_x     <= '0;
      o_vld_q  <= 1'b0;
      o_col_q  <= '0;
      o_data_q <= '0;
      done     <= 1'b0;
    end else begin
      s1_vld  <= accept && last_tile;
      o_vld_q <= s1_vld && !abort;
      done    <= s1_vld && !abort && s1_last;
      if (accept && last_tile) begin
        s1_x    <= s1_nx;
        s1_col  <= col;
        s1_last <= last_col;
      end
      if (s1_vld && !abort) begin
        o_data_q <= o_data_nx;
        o_col_q  <= s1_col;
      end
    end
  end

  assign bus.o_data = o_data_q;
  assign bus.o_vld  = o_vld_q;
  assign bus.o_col  = o_col_q;

endmodule
